frame_reader_fsm: RTL and testbench

//  Read-back counterpart of the capture/CRC/write controller. Reads stored frames out of the

---
 rtl/frame_reader_fsm.sv | 178 +++++++++++++++++
 tb/tb_frame_reader_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader_fsm.sv
// Frame buffer read-back controller: streams FRAME_LEN bytes per frame on a valid/ready
// byte interface and appends a CRC-8 computed on the fly as the last byte of each frame.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; zero-frame requests answered with done
// FETCH | mem_rd_en high for this single cycle
// LOAD  | mem_rdata captured into tx_data, tx_valid raised
// SEND  | data byte offered downstream, held until tx_ready
// CRC   | CRC byte offered with tx_last, held until tx_ready
// NEXT  | CRC reset and counters advanced before the next frame's fetch
module frame_reader_fsm #(
    parameter int          ADDR_W    = 10,
    parameter int          FRAME_LEN = 16,
    parameter int          FRAMES_W  = 8,
    parameter logic [7:0]  CRC_POLY  = 8'h07,
    parameter logic [7:0]  CRC_INIT  = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [FRAMES_W-1:0] nbr_frames,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic                done
);

    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_CRC   = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t              r_state;
    logic [FRAMES_W-1:0] r_nbr;
    logic [FRAMES_W-1:0] r_frame_cnt;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [7:0]          r_crc;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd_en;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_tx_last;
    logic                r_busy;
    logic                r_done;

    logic [7:0]          w_crc_next;
    logic                w_last_byte;
    logic                w_last_frame;

    function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_crc_next   = crc8(r_crc, r_tx_data);
    assign w_last_byte  = (r_byte_cnt == BC_W'(FRAME_LEN - 1));
    assign w_last_frame = (r_frame_cnt == (r_nbr - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_nbr       <= '0;
            r_frame_cnt <= '0;
            r_byte_cnt  <= '0;
            r_crc       <= CRC_INIT;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rd_en    <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_busy     <= 1'b0;
                    if (start) begin
                        if (nbr_frames != '0) begin
                            r_state     <= S_FETCH;
                            r_nbr       <= nbr_frames;
                            r_addr      <= '0;
                            r_byte_cnt  <= '0;
                            r_frame_cnt <= '0;
                            r_crc       <= CRC_INIT;
                            r_rd_en     <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_tx_data  <= mem_rdata;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_crc <= w_crc_next;
                        // The CRC byte is presented straight away so it costs only one cycle.
                        if (w_last_byte) begin
                            r_tx_data <= w_crc_next;
                            r_tx_last <= 1'b1;
                            r_state   <= S_CRC;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_addr     <= r_addr + 1'b1;
                            r_rd_en    <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_CRC: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        if (w_last_frame) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    r_crc       <= CRC_INIT;
                    r_byte_cnt  <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                    r_addr      <= r_addr + 1'b1;
                    r_rd_en     <= 1'b1;
                    r_state     <= S_FETCH;
                end
                default: begin
                    r_rd_en    <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_addr;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_last   = r_tx_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_frame_reader_fsm.sv
// Bench for frame_reader_fsm: three instances (FRAME_LEN 9, FRAME_LEN 1, ADDR_W 4/FRAME_LEN 6)
// checked against a queue model of expected addresses and bytes built from the memory contents.
module tb_frame_reader_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txr;
    logic       start [3];
    logic [7:0] nbr   [3];
    logic       rd_en [3];
    logic [9:0] addr  [3];
    logic [3:0] addr2;
    logic [7:0] rdata [3];
    logic [7:0] txd   [3];
    logic       txv   [3];
    logic       txl   [3];
    logic       busy  [3];
    logic       done  [3];
    logic [7:0] mem   [3][1024];

    int         checks = 0;
    int         failures = 0;
    int         act = 0;
    logic [9:0] exp_addr [$];
    logic [8:0] exp_byte [$];
    int         done_cnt [3];
    int         hs_cnt = 0;
    int         rd_cnt = 0;
    logic       stall_p = 1'b0;
    logic [8:0] stall_v = 9'h0;

    always #5 clk = ~clk;

    frame_reader_fsm #(.ADDR_W(10), .FRAME_LEN(9), .FRAMES_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .nbr_frames(nbr[0]),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr), .tx_last(txl[0]),
        .busy(busy[0]), .done(done[0]));

    frame_reader_fsm #(.ADDR_W(10), .FRAME_LEN(1), .FRAMES_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .nbr_frames(nbr[1]),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr), .tx_last(txl[1]),
        .busy(busy[1]), .done(done[1]));

    frame_reader_fsm #(.ADDR_W(4), .FRAME_LEN(6), .FRAMES_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .nbr_frames(nbr[2]),
        .mem_rd_en(rd_en[2]), .mem_addr(addr2), .mem_rdata(rdata[2]),
        .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(txr), .tx_last(txl[2]),
        .busy(busy[2]), .done(done[2]));

    assign addr[2] = {6'd0, addr2};

    // Buffer read port: data appears one cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k]) rdata[k] <= mem[k][addr[k]];
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Bit-serial reference CRC-8, MSB first.
    function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int bit_i = 7; bit_i >= 0; bit_i--) begin
            fb = c[7] ^ b[bit_i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic build(input int k, input int n);
        int         fl;
        int         am;
        int         a;
        logic [7:0] c;
        logic [7:0] b;
        fl = (k == 0) ? 9 : ((k == 1) ? 1 : 6);
        am = (k == 2) ? 16 : 1024;
        exp_addr.delete();
        exp_byte.delete();
        for (int f = 0; f < n; f++) begin
            c = 8'h00;
            for (int i = 0; i < fl; i++) begin
                a = (f * fl + i) % am;
                exp_addr.push_back(10'(a));
                b = mem[k][a];
                exp_byte.push_back({1'b0, b});
                c = crc_ref(c, b);
            end
            exp_byte.push_back({1'b1, c});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (done[k]) done_cnt[k]++;
                if (k != act) chk("idle_instance_quiet", int'(rd_en[k] | txv[k]), 0);
            end
            if (stall_p) chk("stall_hold", int'({txv[act], txl[act], txd[act]}), int'({1'b1, stall_v}));
            if (rd_en[act]) begin
                rd_cnt++;
                if (exp_addr.size() == 0) chk("extra_rd_en", int'(rd_en[act]), 0);
                else chk("mem_addr", int'(addr[act]), int'(exp_addr.pop_front()));
            end
            if (txv[act] && txr) begin
                hs_cnt++;
                if (exp_byte.size() == 0) chk("extra_byte", int'(txv[act]), 0);
                else chk("tx_byte", int'({txl[act], txd[act]}), int'(exp_byte.pop_front()));
            end
            stall_p = txv[act] && !txr;
            stall_v = {txl[act], txd[act]};
        end
    end

    task automatic run(input int k, input int n, input int mode, input bit poke,
                       output int first_v, output int done_at);
        int cyc;
        int d0;
        act = k;
        build(k, n);
        d0 = done_cnt[k];
        @(posedge clk); #1;
        start[k] = 1'b1;
        nbr[k]   = 8'(n);
        txr      = (mode == 0);
        @(posedge clk); #1;
        start[k] = 1'b0;
        cyc = 0;
        first_v = -1;
        done_at = -1;
        while (done_at < 0 && cyc < 3000) begin
            cyc++;
            if (txv[k] && first_v < 0) first_v = cyc;
            if (done[k]) begin
                done_at = cyc;
                chk("busy_low_with_done", int'(busy[k]), 0);
            end else begin
                chk("busy_while_running", int'(busy[k]), 1);
            end
            if (poke && cyc == 10) begin
                start[k] = 1'b1;
                nbr[k]   = 8'd5;
            end else begin
                start[k] = 1'b0;
            end
            case (mode)
                0:       txr = 1'b1;
                1:       txr = 1'($urandom_range(0, 1));
                default: txr = (cyc <= 20) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
        end
        chk("done_seen", int'(done_at >= 0), 1);
        chk("done_one_cycle", int'(done[k]), 0);
        @(negedge clk);
        chk("bytes_left", exp_byte.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        chk("done_pulses", done_cnt[k] - d0, 1);
    endtask

    initial begin
        int fv;
        int da;
        int h0;
        int r0;
        int d0;
        logic [7:0] c;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            nbr[k]   = 8'd0;
            done_cnt[k] = 0;
            for (int i = 0; i < 1024; i++) mem[k][i] = 8'h00;
        end
        for (int i = 0; i < 9; i++) mem[0][i] = 8'(8'h31 + i);
        mem[1][0] = 8'h01;
        mem[1][1] = 8'hFF;
        for (int i = 0; i < 16; i++) mem[2][i] = 8'(i * 29 + 3);
        txr   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({rd_en[0], addr[0], txd[0], txv[0], txl[0], busy[0], done[0]}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Model pins
        c = 8'h00;
        for (int i = 0; i < 9; i++) c = crc_ref(c, 8'(8'h31 + i));
        chk("model_crc_check_value", int'(c), 'hF4);
        build(1, 2);
        chk("model_t2_b0", int'(exp_byte[0]), 'h001);
        chk("model_t2_b1", int'(exp_byte[1]), 'h107);
        chk("model_t2_b2", int'(exp_byte[2]), 'h0FF);
        chk("model_t2_b3", int'(exp_byte[3]), 'h1F3);
        build(2, 3);
        chk("model_t5_len", exp_byte.size(), 21);
        chk("model_t5_a15", int'(exp_addr[15]), 15);
        chk("model_t5_a16", int'(exp_addr[16]), 0);
        chk("model_t5_a17", int'(exp_addr[17]), 1);

        // T1
        h0 = hs_cnt; r0 = rd_cnt;
        run(0, 1, 0, 1'b0, fv, da);
        chk("t1_first_valid_cycle", fv, 3);
        chk("t1_done_cycle", da, 29);
        chk("t1_handshakes", hs_cnt - h0, 10);
        chk("t1_rd_pulses", rd_cnt - r0, 9);

        // T2
        h0 = hs_cnt;
        run(1, 2, 0, 1'b0, fv, da);
        chk("t2_handshakes", hs_cnt - h0, 4);

        // T3
        r0 = rd_cnt;
        run(0, 1, 1, 1'b0, fv, da);
        chk("t3_rd_pulses_random", rd_cnt - r0, 9);
        r0 = rd_cnt;
        run(0, 1, 2, 1'b0, fv, da);
        chk("t3_rd_pulses_hold", rd_cnt - r0, 9);

        // T4
        r0 = rd_cnt;
        run(0, 0, 0, 1'b0, fv, da);
        chk("t4_done_cycle", da, 1);
        chk("t4_no_valid", fv, -1);
        chk("t4_no_rd_en", rd_cnt - r0, 0);

        // T5
        h0 = hs_cnt;
        run(2, 3, 0, 1'b0, fv, da);
        chk("t5_handshakes", hs_cnt - h0, 21);

        // T6: reset while the third data byte is offered
        act = 0;
        build(0, 1);
        d0 = done_cnt[0];
        @(posedge clk); #1;
        start[0] = 1'b1; nbr[0] = 8'd1; txr = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 100 && exp_byte.size() > 8; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10 && !txv[0]; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_third_byte_offered", int'({txv[0], txd[0]}), 'h133);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", int'({rd_en[0], addr[0], txd[0], txv[0], txl[0], busy[0], done[0]}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_done_on_abort", done_cnt[0] - d0, 0);
        h0 = hs_cnt;
        run(0, 1, 0, 1'b1, fv, da);
        chk("t6_rerun_first_valid", fv, 3);
        chk("t6_rerun_done_cycle", da, 29);
        chk("t6_rerun_handshakes", hs_cnt - h0, 10);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_busy_start_ignored", int'(busy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
